// File: rtl/fifo_pixel_packer.sv
// Read-domain consumer of the pixel async FIFO: packs PIX_PER_WORD pixels per word and emits
// them on a valid/ready stream with a per-line last marker.
module fifo_pixel_packer #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned PIX_PER_WORD   = 4,
  parameter int unsigned WORDS_PER_LINE = 16
) (
  input  logic                               rd_clk,
  input  logic                               rd_rst,
  output logic                               fifo_rd_en,
  input  logic [DATA_WIDTH-1:0]              fifo_rd_data,
  input  logic                               fifo_empty,
  output logic [DATA_WIDTH*PIX_PER_WORD-1:0] m_data,
  output logic                               m_valid,
  input  logic                               m_ready,
  output logic                               m_last
);

  localparam int unsigned WordWidth = DATA_WIDTH * PIX_PER_WORD;
  localparam int unsigned CntWidth  = $clog2(PIX_PER_WORD + 1);
  localparam int unsigned IdxWidth  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;

  localparam logic [CntWidth:0]   Full     = (CntWidth + 1)'(PIX_PER_WORD);
  localparam logic [CntWidth-1:0] LastLane = CntWidth'(PIX_PER_WORD - 1);
  localparam logic [IdxWidth-1:0] LastIdx  = IdxWidth'(WORDS_PER_LINE - 1);

  logic                 pending_q;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [WordWidth-1:0] pack_q, pack_d;
  logic [WordWidth-1:0] m_data_q;
  logic                 m_valid_q;
  logic                 m_last_q;
  logic [IdxWidth-1:0]  word_idx_q, word_idx_d;

  logic                 out_free;
  logic                 handshake;
  logic                 load;
  logic [CntWidth:0]    fill;

  // fill counts lanes occupied once the data returning this cycle has landed.
  always_comb begin
    out_free   = !m_valid_q || m_ready;
    handshake  = m_valid_q && m_ready;
    fill       = {1'b0, cnt_q} + {{CntWidth{1'b0}}, pending_q};
    fifo_rd_en = !rd_rst && !fifo_empty &&
                 ((fill < Full) || (cnt_q == LastLane && pending_q && out_free));
  end

  always_comb begin
    pack_d = pack_q;
    if (pending_q) begin
      for (int unsigned k = 0; k < PIX_PER_WORD; k++) begin
        if (cnt_q == CntWidth'(k)) begin
          pack_d[k*DATA_WIDTH +: DATA_WIDTH] = fifo_rd_data;
        end
      end
    end
  end

  // A full word waits in pack (cnt == PIX_PER_WORD) until the output register frees up.
  always_comb begin
    load  = (fill == Full) && out_free;
    cnt_d = load ? '0 : fill[CntWidth-1:0];
  end

  // word_idx_d is the line position of the word that sits in the output register next cycle.
  always_comb begin
    word_idx_d = word_idx_q;
    if (handshake) begin
      word_idx_d = (word_idx_q == LastIdx) ? '0 : word_idx_q + IdxWidth'(1);
    end
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      pending_q  <= 1'b0;
      cnt_q      <= '0;
      pack_q     <= '0;
      word_idx_q <= '0;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      m_last_q   <= 1'b0;
    end else begin
      pending_q  <= fifo_rd_en && !fifo_empty;
      cnt_q      <= cnt_d;
      pack_q     <= pack_d;
      word_idx_q <= word_idx_d;
      if (load) begin
        m_data_q  <= pack_d;
        m_valid_q <= 1'b1;
        m_last_q  <= (word_idx_d == LastIdx);
      end else if (handshake) begin
        m_valid_q <= 1'b0;
      end
    end
  end

  assign m_data  = m_data_q;
  assign m_valid = m_valid_q;
  assign m_last  = m_last_q;

endmodule

// File: tb/tb_fifo_pixel_packer.sv
// Bench for fifo_pixel_packer: a FIFO model feeds two instances (line lengths 16 and 2); words
// are compared against pixels grouped in push order.
module tb_fifo_pixel_packer;
  localparam int DW   = 8;
  localparam int PPW  = 4;
  localparam int WPL  = 16;
  localparam int WPL2 = 2;
  localparam int WW   = DW * PPW;

  logic          rd_clk = 1'b0;
  logic          rd_rst = 1'b1;
  logic          fifo_clr = 1'b1;
  logic          fifo_rd_en, fifo_rd_en2;
  logic [DW-1:0] fifo_rd_data = '0;
  logic          fifo_empty = 1'b1;
  logic [WW-1:0] m_data, m_data2;
  logic          m_valid, m_valid2, m_last, m_last2;
  logic          m_ready = 1'b0;

  always #5 rd_clk = ~rd_clk;

  fifo_pixel_packer #(.DATA_WIDTH(DW), .PIX_PER_WORD(PPW), .WORDS_PER_LINE(WPL)) u_dut (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(fifo_rd_en), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .m_last(m_last)
  );

  fifo_pixel_packer #(.DATA_WIDTH(DW), .PIX_PER_WORD(PPW), .WORDS_PER_LINE(WPL2)) u_dut_l2 (
    .rd_clk(rd_clk), .rd_rst(rd_rst), .fifo_rd_en(fifo_rd_en2), .fifo_rd_data(fifo_rd_data),
    .fifo_empty(fifo_empty), .m_data(m_data2), .m_valid(m_valid2), .m_ready(m_ready),
    .m_last(m_last2)
  );

  int vectors = 0;
  int miscompares = 0;

  // FIFO model: mem/wr_ptr owned by stimulus, rd_ptr owned by the read side below.
  logic [7:0] mem [0:2047];
  int wr_ptr = 0;
  int rd_ptr = 0;
  int cyc = 0;
  int rd_fires = 0;
  int fire_cyc [0:2047];
  int empty_viol = 0, rst_viol = 0, en_diff = 0;

  always @(posedge rd_clk) begin
    if (fifo_rd_en !== fifo_rd_en2) en_diff++;
    if (rd_rst && fifo_rd_en) rst_viol++;
    if (fifo_empty && fifo_rd_en) empty_viol++;
    if (fifo_clr) begin
      rd_ptr = wr_ptr;
    end else if (fifo_rd_en && !fifo_empty) begin
      fifo_rd_data <= mem[rd_ptr];
      rd_ptr++;
      fire_cyc[rd_fires] = cyc;
      rd_fires++;
    end
    fifo_empty <= (rd_ptr == wr_ptr);
    cyc++;
  end

  // Output monitor: values seen at the falling edge are what the next rising edge takes.
  logic [WW-1:0] got_data [0:511];
  logic          got_last [0:511];
  logic          got_last2 [0:511];
  int            got_cyc [0:511];
  int            got_n = 0;
  int            valid_cycles = 0, stab_viol = 0, diff2 = 0;
  logic          prev_stall = 1'b0;
  logic [WW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;

  always @(negedge rd_clk) begin
    if (rd_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (m_valid) valid_cycles++;
      if (m_data2 !== m_data || m_valid2 !== m_valid) diff2++;
      if (prev_stall && (m_data !== prev_data || m_last !== prev_last || m_valid !== 1'b1))
        stab_viol++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (m_valid && m_ready) begin
        got_data[got_n]  = m_data;
        got_last[got_n]  = m_last;
        got_last2[got_n] = m_last2;
        got_cyc[got_n]   = cyc;
        got_n++;
      end
    end
  end

  // Reference model: pixels pushed since the last reset, in order.
  logic [7:0] sent [$];
  int got_base = 0;

  function automatic logic [WW-1:0] exp_word(input int i);
    logic [WW-1:0] w;
    w = '0;
    for (int k = 0; k < PPW; k++) w[k*DW +: DW] = sent[i*PPW + k];
    return w;
  endfunction

  function automatic logic exp_last(input int i, input int wpl);
    return ((i + 1) % wpl) == 0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge rd_clk);
    #1;
  endtask

  task automatic push(input logic [7:0] v);
    mem[wr_ptr] = v;
    wr_ptr++;
    sent.push_back(v);
  endtask

  task automatic do_reset();
    rd_rst = 1'b1; fifo_clr = 1'b1; m_ready = 1'b0;
    tick(2);
    rd_rst = 1'b0; fifo_clr = 1'b0;
    sent.delete();
    got_base = got_n;
  endtask

  task automatic wait_words(input int n, input int budget);
    int b;
    b = 0;
    while ((got_n - got_base) < n && b < budget) begin
      tick(1);
      b++;
    end
  endtask

  task automatic test_reset();
    tick(2);
    fifo_clr = 1'b0;
    for (int v = 0; v < 4; v++) begin
      mem[wr_ptr] = 8'(v + 8'hE0);
      wr_ptr++;
    end
    tick(3);
    vectors++;
    if (m_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b want 0", m_valid); end
    vectors++;
    if (m_last !== 1'b0) begin miscompares++; $display("FAIL rst_last got %b want 0", m_last); end
    vectors++;
    if (m_data !== '0) begin miscompares++; $display("FAIL rst_data got %h want 0", m_data); end
    vectors++;
    if (fifo_rd_en !== 1'b0) begin
      miscompares++; $display("FAIL rst_rd_en got %b want 0", fifo_rd_en);
    end
    rd_rst = 1'b0;
    #1;
    vectors++;
    if (fifo_rd_en !== 1'b1) begin
      miscompares++; $display("FAIL rst_release_rd_en got %b want 1", fifo_rd_en);
    end
  endtask

  task automatic test_basic();
    int vc0, n;
    do_reset();
    m_ready = 1'b1;
    vc0 = valid_cycles;
    for (int v = 1; v <= 8; v++) push(8'(v));
    wait_words(2, 60);
    tick(8);
    n = got_n - got_base;
    vectors++;
    if (n !== 2) begin miscompares++; $display("FAIL basic_count got %0d want 2", n); end
    for (int i = 0; i < 2 && i < n; i++) begin
      vectors++;
      if (got_data[got_base+i] !== exp_word(i)) begin
        miscompares++;
        $display("FAIL basic_word%0d got %h want %h", i, got_data[got_base+i], exp_word(i));
      end
      vectors++;
      if (got_last[got_base+i] !== 1'b0) begin
        miscompares++; $display("FAIL basic_last%0d got %b want 0", i, got_last[got_base+i]);
      end
    end
    vectors++;
    if (valid_cycles - vc0 !== 2) begin
      miscompares++; $display("FAIL basic_valid_cycles got %0d want 2", valid_cycles - vc0);
    end
  endtask

  task automatic test_backpressure();
    int f0, s0, n;
    do_reset();
    f0 = rd_fires; s0 = stab_viol;
    for (int v = 8'h10; v <= 8'h1B; v++) push(8'(v));
    tick(20);
    vectors++;
    if (m_valid !== 1'b1 || m_data !== exp_word(0)) begin
      miscompares++;
      $display("FAIL bp_hold got %b/%h want 1/%h", m_valid, m_data, exp_word(0));
    end
    vectors++;
    if (rd_fires - f0 !== 8) begin
      miscompares++; $display("FAIL bp_fires got %0d want 8", rd_fires - f0);
    end
    vectors++;
    if (stab_viol - s0 !== 0) begin
      miscompares++; $display("FAIL bp_stable got %0d changes want 0", stab_viol - s0);
    end
    m_ready = 1'b1;
    wait_words(3, 40);
    n = got_n - got_base;
    vectors++;
    if (n !== 3) begin miscompares++; $display("FAIL bp_count got %0d want 3", n); end
    for (int i = 0; i < 3 && i < n; i++) begin
      vectors++;
      if (got_data[got_base+i] !== exp_word(i)) begin
        miscompares++;
        $display("FAIL bp_word%0d got %h want %h", i, got_data[got_base+i], exp_word(i));
      end
    end
    if (n >= 2) begin
      vectors++;
      if (got_cyc[got_base+1] - got_cyc[got_base] !== 1) begin
        miscompares++;
        $display("FAIL bp_gap got %0d want 1", got_cyc[got_base+1] - got_cyc[got_base]);
      end
    end
  endtask

  task automatic test_line_marker();
    int n;
    do_reset();
    m_ready = 1'b1;
    for (int v = 0; v < 16; v++) push(8'(8'h30 + v));
    wait_words(4, 60);
    n = got_n - got_base;
    vectors++;
    if (n !== 4) begin miscompares++; $display("FAIL line_count got %0d want 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      vectors++;
      if (got_last2[got_base+i] !== exp_last(i, WPL2) || got_last[got_base+i] !== 1'b0) begin
        miscompares++;
        $display("FAIL line_last%0d got %b/%b want %b/0", i, got_last2[got_base+i],
                 got_last[got_base+i], exp_last(i, WPL2));
      end
    end
  endtask

  task automatic test_starved();
    int vc0, n;
    do_reset();
    m_ready = 1'b1;
    vc0 = valid_cycles;
    for (int v = 0; v < 3; v++) push(8'(8'h60 + v));
    tick(12);
    vectors++;
    if (valid_cycles - vc0 !== 0) begin
      miscompares++; $display("FAIL starve_early got %0d valid cycles want 0", valid_cycles - vc0);
    end
    push(8'h63);
    wait_words(1, 20);
    tick(6);
    n = got_n - got_base;
    vectors++;
    if (n !== 1) begin miscompares++; $display("FAIL starve_count got %0d want 1", n); end
    if (n >= 1) begin
      vectors++;
      if (got_data[got_base] !== exp_word(0)) begin
        miscompares++;
        $display("FAIL starve_word got %h want %h", got_data[got_base], exp_word(0));
      end
    end
    vectors++;
    if (empty_viol !== 0) begin
      miscompares++; $display("FAIL starve_rd_en_on_empty got %0d want 0", empty_viol);
    end
  endtask

  task automatic test_throughput();
    int f0, n;
    do_reset();
    rd_rst = 1'b1;
    for (int v = 0; v < 64; v++) push(8'($urandom));
    tick(3);
    f0 = rd_fires;
    m_ready = 1'b1;
    rd_rst = 1'b0;
    wait_words(16, 120);
    n = got_n - got_base;
    vectors++;
    if (n !== 16) begin miscompares++; $display("FAIL tput_count got %0d want 16", n); end
    for (int i = 0; i < 16 && i < n; i++) begin
      vectors++;
      if (got_data[got_base+i] !== exp_word(i) || got_last[got_base+i] !== exp_last(i, WPL) ||
          got_last2[got_base+i] !== exp_last(i, WPL2)) begin
        miscompares++;
        $display("FAIL tput_word%0d got %h/%b/%b want %h/%b/%b", i, got_data[got_base+i],
                 got_last[got_base+i], got_last2[got_base+i], exp_word(i), exp_last(i, WPL),
                 exp_last(i, WPL2));
      end
      if (i > 0) begin
        vectors++;
        if (got_cyc[got_base+i] - got_cyc[got_base+i-1] !== PPW) begin
          miscompares++;
          $display("FAIL tput_gap%0d got %0d want %0d", i,
                   got_cyc[got_base+i] - got_cyc[got_base+i-1], PPW);
        end
      end
    end
    vectors++;
    if (rd_fires - f0 !== 64) begin
      miscompares++; $display("FAIL tput_fires got %0d want 64", rd_fires - f0);
    end else begin
      vectors++;
      if (fire_cyc[f0+63] - fire_cyc[f0] !== 63) begin
        miscompares++;
        $display("FAIL tput_rd_en_span got %0d want 63", fire_cyc[f0+63] - fire_cyc[f0]);
      end
    end
  endtask

  task automatic test_mid_reset();
    int f0, b, n;
    do_reset();
    m_ready = 1'b1;
    f0 = rd_fires;
    for (int v = 0; v < 8; v++) push(8'(8'h50 + v));
    b = 0;
    while (rd_fires - f0 < 3 && b < 20) begin
      tick(1);
      b++;
    end
    vectors++;
    if (rd_fires - f0 !== 3) begin
      miscompares++; $display("FAIL midrst_fires got %0d want 3", rd_fires - f0);
    end
    rd_rst = 1'b1;
    tick(1);
    vectors++;
    if ({m_valid, m_last, fifo_rd_en} !== 3'b000 || m_data !== '0) begin
      miscompares++;
      $display("FAIL midrst_outputs got v%b l%b en%b d%h want all 0", m_valid, m_last,
               fifo_rd_en, m_data);
    end
    do_reset();
    m_ready = 1'b1;
    for (int v = 0; v < 4; v++) push(8'(8'hA0 + v));
    wait_words(1, 30);
    tick(6);
    n = got_n - got_base;
    vectors++;
    if (n !== 1) begin miscompares++; $display("FAIL midrst_count got %0d want 1", n); end
    if (n >= 1) begin
      vectors++;
      if (got_data[got_base] !== 32'hA3A2A1A0) begin
        miscompares++; $display("FAIL midrst_word got %h want a3a2a1a0", got_data[got_base]);
      end
    end
  endtask

  task automatic test_random();
    int rate, n, want;
    do_reset();
    rate = 2;
    for (int c = 0; c < 800; c++) begin
      if (c % 100 == 0) rate = $urandom_range(0, 4);
      if ($urandom_range(0, 3) < rate) push(8'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      tick(1);
    end
    m_ready = 1'b1;
    want = sent.size() / PPW;
    wait_words(want, 600);
    tick(4);
    n = got_n - got_base;
    vectors++;
    if (n !== want) begin miscompares++; $display("FAIL rand_count got %0d want %0d", n, want); end
    for (int i = 0; i < want && i < n; i++) begin
      vectors++;
      if (got_data[got_base+i] !== exp_word(i) || got_last[got_base+i] !== exp_last(i, WPL) ||
          got_last2[got_base+i] !== exp_last(i, WPL2)) begin
        miscompares++;
        $display("FAIL rand_word%0d got %h/%b/%b want %h/%b/%b", i, got_data[got_base+i],
                 got_last[got_base+i], got_last2[got_base+i], exp_word(i), exp_last(i, WPL),
                 exp_last(i, WPL2));
      end
    end
    vectors++;
    if (stab_viol !== 0) begin miscompares++; $display("FAIL rand_stable got %0d want 0", stab_viol); end
    vectors++;
    if (empty_viol !== 0 || rst_viol !== 0) begin
      miscompares++;
      $display("FAIL rand_rd_en_gating got empty %0d rst %0d want 0 0", empty_viol, rst_viol);
    end
    vectors++;
    if (diff2 !== 0 || en_diff !== 0) begin
      miscompares++;
      $display("FAIL rand_instance_agree got %0d/%0d want 0/0", diff2, en_diff);
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_backpressure();
    test_line_marker();
    test_starved();
    test_throughput();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fifo_pixel_packer.md
# fifo_pixel_packer

Read-side consumer of the pixel async FIFO, running entirely in the read clock domain. It drains 8-bit pixels through the FIFO's `rd_en`/`rd_data`/`empty` port and absorbs the FIFO's one-cycle registered read latency. It packs `PIX_PER_WORD` pixels into one word and presents the words on a valid/ready stream toward the processing block, with a per-line `m_last` marker.

## Interface
- `DATA_WIDTH`, 8: pixel width; must match the FIFO `DATA_WIDTH`.
- `PIX_PER_WORD`, 4: pixels per output word; a power of two, ≥2.
- `WORDS_PER_LINE`, 16: output words per line; `m_last` period; ≥1.
- `rd_clk` in 1: read-domain clock; same clock as the FIFO read port.
- `rd_rst` in 1: synchronous, active-high reset.
- `fifo_rd_en` out 1: FIFO read request; combinational.
- `fifo_rd_data` in DATA_WIDTH: FIFO registered read data.
- `fifo_empty` in 1: FIFO empty flag.
- `m_data` out DATA_WIDTH*PIX_PER_WORD: packed word; pixel k in bits [k*DATA_WIDTH +: DATA_WIDTH], first-read pixel in k=0.
- `m_valid` out 1: `m_data`/`m_last` valid.
- `m_ready` in 1: downstream accept.
- `m_last` out 1: word is the last of a line.

## Operation
- Registers:
  - `pending`: a read was issued last cycle, so data arrives this cycle.
  - `cnt`: pack lanes filled, 0..PIX_PER_WORD.
  - `pack` shift/lane register.
  - Output register: `m_data`, `m_valid`, `m_last`.
  - `word_idx`: 0..WORDS_PER_LINE-1.
- Handshake definitions:
  - Read fire: `fifo_rd_en && !fifo_empty`. On the next edge, `pending <= read fire`.
  - Output handshake: `m_valid && m_ready`.
  - `out_free` = `!m_valid || m_ready`.
- `fifo_rd_en` = `!fifo_empty && ((cnt + pending) < PIX_PER_WORD || (cnt == PIX_PER_WORD-1 && pending && out_free))`. This never over-commits lanes and sustains 1 pixel/cycle when downstream is ready.
- When `pending` = 1:
  - `fifo_rd_data` is written into lane `cnt`, and `cnt` increments.
- Word completion, when the lane count reaches PIX_PER_WORD:
  - If `out_free`: the word is copied to the output register that edge, `m_valid` <= 1, `m_last` <= (`word_idx == WORDS_PER_LINE-1`), and `cnt` <= 0.
  - Otherwise the word holds in `pack` with `cnt` = PIX_PER_WORD. No reads are issued, since `cnt + pending` ≥ PIX_PER_WORD.
  - The held word transfers on the first edge where `out_free`.
- `word_idx` increments on each output handshake and wraps to 0 after `WORDS_PER_LINE-1`.
- Output handshake with no new word loading: `m_valid` <= 0.
- Output handshake with a word loading the same edge: `m_valid` stays 1 and the new word replaces the old, so there is no bubble.
- While `m_valid && !m_ready`, `m_data` and `m_last` are stable.
- `fifo_empty` going high mid-word: the partial word waits; there is no timeout and no padding.
- Reset, when `rd_rst` = 1 at an edge:
  - `pending`, `cnt`, `pack`, `word_idx`, `m_valid`, `m_last` and `m_data` all become 0.
  - `fifo_rd_en` is forced to 0 while `rd_rst` is high.
  - A read in flight at reset is discarded.
  - `rd_rst` is asserted together with the FIFO read-domain reset.

## Timing
- Read issued at edge t: data sampled at edge t+1, and the completed word is visible on `m_data` after edge t+1 when it is the last pixel.
- Minimum latency, from the first read fire of a word to `m_valid`: PIX_PER_WORD cycles.
- Steady-state throughput with `m_ready` held 1 and FIFO non-empty: one word every PIX_PER_WORD cycles, with no bubbles.
- `fifo_rd_en` depends combinationally on `fifo_empty`, `m_valid`, `m_ready`, `cnt`, `pending` and `rd_rst`, with no other inputs.
- Outputs after reset: `fifo_rd_en` = 0 until `fifo_empty` deasserts, `m_valid` = 0, `m_last` = 0, `m_data` = 0.

## Test plan
- **Basic packing:**
  - Stimulus: write 0x01..0x08 into the FIFO, hold `m_ready` = 1.
  - Response: exactly two words, 0x04030201 then 0x08070605, each `m_valid` for one cycle, `m_last` = 0.
- **Backpressure:**
  - Stimulus: 12 pixels 0x10..0x1B, `m_ready` = 0 for 20 cycles, then 1.
  - Response: `m_data` holds 0x13121110 stable, and exactly 8 read fires occur during the stall (word held in output register plus `pack` full).
  - Response after release: words 0x17161514 and 0x1B1A1918 follow back-to-back.
- **Line marker:**
  - Stimulus: `WORDS_PER_LINE` = 2, 16 pixels.
  - Response: `m_last` = 1 on words 2 and 4 only, and `word_idx` wraps.
- **Starved FIFO:**
  - Stimulus: 3 pixels, 10 idle cycles, 1 pixel.
  - Response: no `m_valid` until the 4th pixel arrives, then a single word, and `fifo_rd_en` = 0 whenever `fifo_empty` = 1.
- **Throughput:**
  - Stimulus: 64 pixels preloaded, `m_ready` = 1.
  - Response: 16 words on 16 consecutive 4-cycle boundaries, and `fifo_rd_en` high continuously until the FIFO is empty.
- **Mid-word reset:**
  - Stimulus: pulse `rd_rst` for 1 cycle after 2 pixels of a word plus one in-flight read, then reset both ends and write 0xA0..0xA3.
  - Response: all outputs 0 after the reset edge, and the next word is exactly 0xA3A2A1A0 with no stale lanes.
